// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port integer register bank.
package regfile_pkg;

  typedef enum logic {CLEAR, READY} rf_state_t;

  // Number of entries addressed by a bank of the given address width.
  function automatic int words(input int bank_width);
    return 1 << bank_width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/writeback-side bus of the register bank: operand and debug reads,
// two write ports, scoreboard set and the busy indication.
interface regfile_mp_if #(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64
);
  logic [BANK_WIDTH-1:0] ra1;
  logic [BANK_WIDTH-1:0] ra2;
  logic [BANK_WIDTH-1:0] ra_db;
  logic [WIDTH-1:0]      rd1;
  logic [WIDTH-1:0]      rd2;
  logic [WIDTH-1:0]      rd_db;
  logic                  pend1;
  logic                  pend2;
  logic                  we3;
  logic [BANK_WIDTH-1:0] wa3;
  logic [WIDTH-1:0]      wd3;
  logic                  we4;
  logic [BANK_WIDTH-1:0] wa4;
  logic [WIDTH-1:0]      wd4;
  logic                  pend_set;
  logic [BANK_WIDTH-1:0] pend_wa;
  logic                  busy;

  modport master (
    output ra1, ra2, ra_db, we3, wa3, wd3, we4, wa4, wd4, pend_set, pend_wa,
    input  rd1, rd2, rd_db, pend1, pend2, busy
  );

  modport slave (
    input  ra1, ra2, ra_db, we3, wa3, wd3, we4, wa4, wd4, pend_set, pend_wa,
    output rd1, rd2, rd_db, pend1, pend2, busy
  );
endinterface

// File: rtl/regfile_mp_clear_ctrl.sv
// Post-reset clear sequencer: walks every bank entry once, one per cycle,
// and holds busy high until the last entry has been zeroed.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int BANK_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clr_we,
  output logic [BANK_WIDTH-1:0] clr_addr
);

  localparam int                    WORDS = words(BANK_WIDTH);
  localparam logic [BANK_WIDTH-1:0] LAST  = BANK_WIDTH'(WORDS - 1);

  rf_state_t             state;
  logic [BANK_WIDTH-1:0] clr_idx;

  // Sequencer state, index counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Two-write-port integer register bank with scoreboard bits and a hardware
// clear sequencer. Optional macro REGFILE_BYPASS_EN adds same-cycle
// write-to-read forwarding (port 4 over port 3) on all read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64
) (
  input logic        clk,
  input logic        reset,
  regfile_mp_if.slave bus
);

  localparam int WORDS = words(BANK_WIDTH);

  logic [WIDTH-1:0]      ram [WORDS];
  logic [WORDS-1:0]      pend;
  logic                  busy;
  logic                  clr_we;
  logic [BANK_WIDTH-1:0] clr_addr;
  logic                  wr3;
  logic                  wr4;

  regfile_clear_ctrl #(.BANK_WIDTH(BANK_WIDTH)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes commit only outside the clear sequence and never to entry 0.
  assign wr3 = !busy && bus.we3 && (bus.wa3 != '0);
  assign wr4 = !busy && bus.we4 && (bus.wa4 != '0);

  // Storage: clear sequencer owns the bank while busy; port 4 is issued
  // last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_addr] <= '0;
    end else begin
      if (wr3) ram[bus.wa3] <= bus.wd3;
      if (wr4) ram[bus.wa4] <= bus.wd4;
    end
  end

  // Scoreboard: writeback clears, issue sets; a set issued last wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (!busy) begin
      if (wr3) pend[bus.wa3] <= 1'b0;
      if (wr4) pend[bus.wa4] <= 1'b0;
      if (bus.pend_set && (bus.pend_wa != '0)) pend[bus.pend_wa] <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [BANK_WIDTH-1:0] wa,
                                   input logic [BANK_WIDTH-1:0] ra);
    return we && (wa == ra) && (wa != '0);
  endfunction
`endif

  // Read ports: forced to zero while clearing and for entry 0.
  always_comb begin
    bus.rd1   = '0;
    bus.rd2   = '0;
    bus.rd_db = '0;
    bus.pend1 = 1'b0;
    bus.pend2 = 1'b0;
    if (!busy) begin
      if (bus.ra1 != '0) begin
        bus.rd1   = ram[bus.ra1];
        bus.pend1 = pend[bus.ra1];
      end
      if (bus.ra2 != '0) begin
        bus.rd2   = ram[bus.ra2];
        bus.pend2 = pend[bus.ra2];
      end
      if (bus.ra_db != '0) bus.rd_db = ram[bus.ra_db];
`ifdef REGFILE_BYPASS_EN
      if (fwd_hit(bus.we3, bus.wa3, bus.ra1))   begin bus.rd1 = bus.wd3; bus.pend1 = 1'b0; end
      if (fwd_hit(bus.we4, bus.wa4, bus.ra1))   begin bus.rd1 = bus.wd4; bus.pend1 = 1'b0; end
      if (fwd_hit(bus.we3, bus.wa3, bus.ra2))   begin bus.rd2 = bus.wd3; bus.pend2 = 1'b0; end
      if (fwd_hit(bus.we4, bus.wa4, bus.ra2))   begin bus.rd2 = bus.wd4; bus.pend2 = 1'b0; end
      if (fwd_hit(bus.we3, bus.wa3, bus.ra_db)) bus.rd_db = bus.wd3;
      if (fwd_hit(bus.we4, bus.wa4, bus.ra_db)) bus.rd_db = bus.wd4;
`endif
    end
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequencing, write priority, x0,
// scoreboard set/clear and read latency (with or without REGFILE_BYPASS_EN).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.BANK_WIDTH(5), .WIDTH(64)) bus ();

  regfile_mp #(.BANK_WIDTH(5), .WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0;
    bus.we4 = 1'b0; bus.wa4 = '0; bus.wd4 = '0;
    bus.pend_set = 1'b0; bus.pend_wa = '0;
  endtask

  // Count cycles until busy drops, bounded; also checks reads stay zero while busy.
  task automatic busy_window(input string tag, output int cycles);
    logic zero_ok;
    zero_ok = 1'b1;
    cycles  = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      if (bus.rd1 !== 64'd0 || bus.rd2 !== 64'd0 || bus.rd_db !== 64'd0 ||
          bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0)
        zero_ok = 1'b0;
      tick();
      cycles++;
    end
    chk({tag, "_reads_zero_while_busy"}, 64'(zero_ok), 64'd1);
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.ra1 = 5'd31; bus.ra2 = 5'd30; bus.ra_db = 5'd4;

    // Test 1 / 6: reset, busy length, writes and pend_set ignored while busy.
    tick();
    reset = 1'b0;
    chk("reset_busy", 64'(bus.busy), 64'd1);
    chk("reset_pend1", 64'(bus.pend1), 64'd0);
    bus.we3 = 1'b1; bus.wa3 = 5'd4; bus.wd3 = 64'hDEAD_BEEF;
    bus.we4 = 1'b1; bus.wa4 = 5'd6; bus.wd4 = 64'hCAFE;
    bus.pend_set = 1'b1; bus.pend_wa = 5'd4;
    busy_window("t1", cyc);
    chk("t1_busy_cycles", 64'(cyc), 64'd32);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      bus.ra1 = 5'(i);
      #1;
      chk($sformatf("t1_rd1_x%0d", i), bus.rd1, 64'd0);
      chk($sformatf("t1_pend1_x%0d", i), 64'(bus.pend1), 64'd0);
    end
    bus.ra_db = 5'd4; bus.ra2 = 5'd6; bus.ra1 = 5'd4;
    #1;
    chk("t6_rd_db_x4", bus.rd_db, 64'd0);
    chk("t6_rd2_x6", bus.rd2, 64'd0);
    chk("t6_pend1_x4", 64'(bus.pend1), 64'd0);

    // Test 2: put data in x12, reset at clr_idx=10, sequence restarts.
    bus.we3 = 1'b1; bus.wa3 = 5'd12; bus.wd3 = 64'h77;
    tick();
    idle_inputs();
    bus.ra1 = 5'd12;
    #1;
    chk("t2_x12_written", bus.rd1, 64'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_busy_at_idx10", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_window("t2", cyc);
    chk("t2_busy_cycles", 64'(cyc), 64'd32);
    chk("t2_x12_cleared", bus.rd1, 64'd0);

    // Test 3: same-address priority, x0 write dropped, dual commit.
    bus.we3 = 1'b1; bus.wa3 = 5'd5; bus.wd3 = 64'hAAAA;
    bus.we4 = 1'b1; bus.wa4 = 5'd5; bus.wd4 = 64'h5555;
    tick();
    idle_inputs();
    bus.ra1 = 5'd5;
    #1;
    chk("t3_prio_x5", bus.rd1, 64'h5555);
    bus.we3 = 1'b1; bus.wa3 = 5'd0; bus.wd3 = 64'hFFFF;
    tick();
    idle_inputs();
    bus.ra1 = 5'd0;
    #1;
    chk("t3_x0_zero", bus.rd1, 64'd0);
    bus.we3 = 1'b1; bus.wa3 = 5'd10; bus.wd3 = 64'h111;
    bus.we4 = 1'b1; bus.wa4 = 5'd11; bus.wd4 = 64'h222;
    tick();
    idle_inputs();
    bus.ra1 = 5'd10; bus.ra2 = 5'd11; bus.ra_db = 5'd5;
    #1;
    chk("t3_dual_x10", bus.rd1, 64'h111);
    chk("t3_dual_x11", bus.rd2, 64'h222);
    chk("t3_db_x5", bus.rd_db, 64'h5555);

    // Test 4: scoreboard set, hold, clear by writeback; set beats clear.
    bus.ra1 = 5'd7;
    bus.pend_set = 1'b1; bus.pend_wa = 5'd7;
    tick();
    bus.pend_set = 1'b0;
    #1;
    chk("t4_pend_a", 64'(bus.pend1), 64'd1);
    tick();
    chk("t4_pend_b", 64'(bus.pend1), 64'd1);
    bus.we3 = 1'b1; bus.wa3 = 5'd7; bus.wd3 = 64'h7777;
    tick();
    idle_inputs();
    #1;
    chk("t4_pend_c", 64'(bus.pend1), 64'd0);
    chk("t4_rd1_x7", bus.rd1, 64'h7777);
    bus.pend_set = 1'b1; bus.pend_wa = 5'd9;
    bus.we4 = 1'b1; bus.wa4 = 5'd9; bus.wd4 = 64'h9999;
    tick();
    idle_inputs();
    bus.ra2 = 5'd9;
    #1;
    chk("t4_set_wins_x9", 64'(bus.pend2), 64'd1);
    chk("t4_rd2_x9", bus.rd2, 64'h9999);
    bus.pend_set = 1'b1; bus.pend_wa = 5'd0;
    tick();
    idle_inputs();
    bus.ra2 = 5'd0;
    #1;
    chk("t4_pend_x0", 64'(bus.pend2), 64'd0);

    // Test 5: write-to-read latency on rd2, forwarding when enabled.
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 64'h1111;
    tick();
    idle_inputs();
    bus.ra2 = 5'd3; bus.ra_db = 5'd3;
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 64'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t5_same_cycle_rd2", bus.rd2, 64'h1234);
    chk("t5_same_cycle_db", bus.rd_db, 64'h1234);
`else
    chk("t5_same_cycle_rd2", bus.rd2, 64'h1111);
    chk("t5_same_cycle_db", bus.rd_db, 64'h1111);
`endif
    tick();
    idle_inputs();
    #1;
    chk("t5_next_cycle_rd2", bus.rd2, 64'h1234);
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 64'hAB;
    bus.we4 = 1'b1; bus.wa4 = 5'd3; bus.wd4 = 64'hCD;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t5_fwd_prio_rd2", bus.rd2, 64'hCD);
`else
    chk("t5_fwd_prio_rd2", bus.rd2, 64'h1234);
`endif
    tick();
    idle_inputs();
    #1;
    chk("t5_after_prio_rd2", bus.rd2, 64'hCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-write-port register file, the next generation of the core's integer register bank.
- Two write ports with fixed priority; two async read ports plus a debug read port.
- Per-register pending (scoreboard) bits for the issue stage.
- Hardware clear sequencer that zeroes the bank after reset.
- Register 0 is hardwired to zero. Sits between decode/issue and writeback in the pipelined core.

Parameters:
- BANK_WIDTH, 5, address width; WORDS = 2**BANK_WIDTH entries.
- WIDTH, 64, data width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ra1, ra2  in  BANK_WIDTH  read addresses, operand A/B.
- ra_db  in  BANK_WIDTH  debug read address.
- rd1, rd2  out  WIDTH  async read data for ra1/ra2.
- rd_db  out  WIDTH  async debug read data.
- pend1, pend2  out  1  pending bit of ra1/ra2 (combinational).
- we3  in  1  write enable, port 3 (low priority).
- wa3  in  BANK_WIDTH  write address, port 3.
- wd3  in  WIDTH  write data, port 3.
- we4  in  1  write enable, port 4 (high priority).
- wa4  in  BANK_WIDTH  write address, port 4.
- wd4  in  WIDTH  write data, port 4.
- pend_set  in  1  mark register pend_wa as awaiting writeback.
- pend_wa  in  BANK_WIDTH  register to mark pending.
- busy  out  1  clear sequence in progress; writes and pend_set are ignored.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: any posedge with reset=1 sets state<=CLEAR, clr_idx<=0, all pend bits<=0, busy=1. Storage is not cleared by reset itself.
- CLEAR state: one entry per cycle; ram[clr_idx]<=0, clr_idx++.
  - When clr_idx==WORDS-1 is written, next state is READY.
  - busy is high for exactly WORDS cycles after reset deasserts, then low.
- Reset asserted mid-CLEAR restarts the sequence at index 0.
- While busy=1:
  - rd1, rd2, rd_db read 0.
  - pend1 and pend2 read 0.
  - we3, we4 and pend_set have no effect.
- READY, write commit: weN=1 and waN!=0 writes ram[waN]<=wdN at posedge.
  - Writes to address 0 are dropped.
  - If both ports target the same nonzero address in one cycle, wd4 is stored.
  - Different addresses both commit in the same cycle.
- Reads: rdX = ram[raX] asynchronously; address 0 always returns 0.
  - Without the bypass feature, a write becomes visible the cycle after its posedge.
- Scoreboard, set: pend_set=1 and pend_wa!=0 sets pend[pend_wa].
- Scoreboard, clear: any committed write (port 3 or 4) clears pend[waN].
- Set and clear of the same register in one cycle: set wins (a new producer has been issued).
- pend[0] is constant 0. pendX = pend[raX].
- Latency: write-to-read 1 cycle (0 with bypass); pend set/clear visible next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding on rd1, rd2 and rd_db.
  - If weN=1, waN==raX and waN!=0, rdX=wdN; port 4 takes priority over port 3.
  - pendX reads 0 when a forwarding write to raX is present in that cycle.
  - Forwarding is disabled while busy=1.
- Undefined: reads return the registered contents only; the pend logic is unchanged.

Decomposition:
- regfile_pkg contains:
  - typedef enum logic {CLEAR, READY} rf_state_t;
  - a words() helper function returning 2**BANK_WIDTH.
- Sub-module regfile_clear_ctrl owns the state register, the clr_idx counter and busy. It exports clr_we and clr_addr to the bank.

Test Plan:
1. Reset 1 cycle, then release -> busy=1 for exactly 32 cycles; afterwards all 32 ra1 reads return 0 and pend1=0.
2. Reset during CLEAR at clr_idx=10 -> clr_idx restarts at 0; busy stays high for 32 further cycles.
3. Same-cycle writes we3: x5<=0xAAAA and we4: x5<=0x5555 -> next cycle rd1(ra1=5)=0x5555. Write x0<=0xFFFF -> rd1(ra1=0)=0.
4. pend_set with pend_wa=7, then we3 to x7 two cycles later -> pend1(ra1=7) reads 1, 1, then 0. Simultaneous pend_set x9 and we4 x9 -> pend stays 1.
5. With REGFILE_BYPASS_EN, write x3<=0x1234 with ra2=3 in the same cycle -> rd2=0x1234 that cycle. Without the macro -> rd2 shows the old value, then 0x1234 the next cycle.
6. we3=1 with wa3=4 while busy=1 -> after READY, rd_db(ra_db=4)=0.
